// File: rtl/entropy_src_markov_sched.sv
// Window scheduler for the Markov health test datapath.
// Sequences the datapath through boot/run, counts valid RNG samples per window,
// emits the end-of-window pulse, tracks hi/lo watermarks of the reported test
// counts and raises a sticky alert after enough consecutive failing windows.
//
// Sample handshake: entropy_bit_vld_i is a single-cycle qualifier with no
// backpressure (there is no ready). A sample is consumed in the cycle its valid
// is high, provided the block is in RUN and not in the wrap cycle. A sample
// arriving in the wrap cycle is dropped here, matching the datapath, which
// discards it too.
module entropy_src_markov_sched #(
  parameter int RegWidth     = 16,
  parameter int FailCntWidth = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic                    clear_i,
  input  logic                    entropy_bit_vld_i,
  input  logic [RegWidth-1:0]     window_size_i,
  input  logic [FailCntWidth-1:0] alert_thresh_i,
  input  logic [RegWidth-1:0]     test_cnt_hi_i,
  input  logic [RegWidth-1:0]     test_cnt_lo_i,
  input  logic                    test_fail_hi_pulse_i,
  input  logic                    test_fail_lo_pulse_i,
  input  logic                    count_err_i,
  output logic                    active_o,
  output logic                    clear_o,
  output logic                    window_wrap_pulse_o,
  output logic [RegWidth-1:0]     hi_watermark_o,
  output logic [RegWidth-1:0]     lo_watermark_o,
  output logic [FailCntWidth-1:0] fail_cnt_o,
  output logic [FailCntWidth-1:0] total_fail_cnt_o,
  output logic                    alert_o,
  output logic                    err_o,
  output logic [2:0]              dbg_state_o
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StBoot  = 3'd1,
    StRun   = 3'd2,
    StAlert = 3'd3,
    StError = 3'd4
  } state_e;

  localparam logic [RegWidth-1:0]     MinSize  = RegWidth'(2);
  localparam logic [RegWidth-1:0]     WmLoInit = {RegWidth{1'b1}};
  localparam logic [FailCntWidth-1:0] FailMax  = {FailCntWidth{1'b1}};

  state_e                  state_q, state_d;
  logic                    active_q, active_d;
  logic                    wrap_q, wrap_d;
  logic [RegWidth-1:0]     cnt_q, cnt_d;
  logic [RegWidth-1:0]     size_q, size_d;
  logic [RegWidth-1:0]     hi_wm_q, hi_wm_d;
  logic [RegWidth-1:0]     lo_wm_q, lo_wm_d;
  logic [FailCntWidth-1:0] fail_cnt_q, fail_cnt_d;
  logic [FailCntWidth-1:0] total_q, total_d;
  logic                    alert_q, alert_d;
  logic                    err_q, err_d;

  logic [RegWidth-1:0]     eff_size;
  logic [RegWidth-1:0]     last_idx;
  logic                    win_fail;

  // Windows shorter than a sample pair are stretched to two samples.
  always_comb begin
    eff_size = (size_q < MinSize) ? MinSize : size_q;
    last_idx = eff_size - RegWidth'(1);
    win_fail = test_fail_hi_pulse_i | test_fail_lo_pulse_i;
  end

  // Next-state logic: error beats disable, disable beats clear, clear beats window work.
  always_comb begin
    state_d    = state_q;
    wrap_d     = 1'b0;
    cnt_d      = cnt_q;
    size_d     = size_q;
    hi_wm_d    = hi_wm_q;
    lo_wm_d    = lo_wm_q;
    fail_cnt_d = fail_cnt_q;
    total_d    = total_q;
    alert_d    = alert_q;
    err_d      = err_q;

    if (count_err_i) begin
      state_d = StError;
      err_d   = 1'b1;
      cnt_d   = '0;
    end else begin
      if (clear_i) begin
        cnt_d      = '0;
        hi_wm_d    = '0;
        lo_wm_d    = WmLoInit;
        fail_cnt_d = '0;
        total_d    = '0;
        alert_d    = 1'b0;
        err_d      = 1'b0;
      end

      if (!enable_i) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          StIdle: state_d = StBoot;
          StBoot: begin
            state_d = StRun;
            size_d  = window_size_i;
            cnt_d   = '0;
          end
          StRun: begin
            if (clear_i) begin
              // Stay in RUN; the window restarts from zero with stats cleared.
            end else if (wrap_q) begin
              // Wrap cycle: datapath counts and fail pulses are valid now.
              if (test_cnt_hi_i > hi_wm_q) hi_wm_d = test_cnt_hi_i;
              if (test_cnt_lo_i < lo_wm_q) lo_wm_d = test_cnt_lo_i;
              if (win_fail) begin
                if (fail_cnt_q != FailMax) fail_cnt_d = fail_cnt_q + FailCntWidth'(1);
                if (total_q != FailMax)    total_d    = total_q + FailCntWidth'(1);
              end else begin
                fail_cnt_d = '0;
              end
              if ((alert_thresh_i != '0) && (fail_cnt_d >= alert_thresh_i)) begin
                state_d = StAlert;
                alert_d = 1'b1;
              end
            end else if (entropy_bit_vld_i) begin
              if (cnt_q == last_idx) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
                size_d = window_size_i;
              end else begin
                cnt_d = cnt_q + RegWidth'(1);
              end
            end
          end
          StAlert, StError: begin
            if (clear_i) state_d = StBoot;
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  // active is registered from the next state so it tracks RUN exactly.
  always_comb begin
    active_d = (state_d == StRun);
  end

  // State and datapath-control registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      active_q   <= 1'b0;
      wrap_q     <= 1'b0;
      cnt_q      <= '0;
      size_q     <= '0;
      hi_wm_q    <= '0;
      lo_wm_q    <= WmLoInit;
      fail_cnt_q <= '0;
      total_q    <= '0;
      alert_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      wrap_q     <= wrap_d;
      cnt_q      <= cnt_d;
      size_q     <= size_d;
      hi_wm_q    <= hi_wm_d;
      lo_wm_q    <= lo_wm_d;
      fail_cnt_q <= fail_cnt_d;
      total_q    <= total_d;
      alert_q    <= alert_d;
      err_q      <= err_d;
    end
  end

  // Output mapping; clear_o passes the CSR clear straight through to the datapath.
  always_comb begin
    active_o            = active_q;
    clear_o             = (state_q == StBoot) | clear_i;
    window_wrap_pulse_o = wrap_q;
    hi_watermark_o      = hi_wm_q;
    lo_watermark_o      = lo_wm_q;
    fail_cnt_o          = fail_cnt_q;
    total_fail_cnt_o    = total_q;
    alert_o             = alert_q;
    err_o               = err_q;
    dbg_state_o         = state_q;
  end

endmodule
